// File: rtl/reduce_tree_pipe.sv
// reduce_tree_pipe
//   Pipelined N-input reduction tree. Folds in_data to one bit with the
//   per-transaction operation in_op (00 AND, 01 OR, 10 XOR, 11 NAND).
//   A register stage sits after every LEVELS_PER_STAGE gate levels, so the
//   latency is DEPTH = ceil(ceil(log2(N_INPUTS)) / LEVELS_PER_STAGE) cycles.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_data/in_op          operand vector (bit 0 = leftmost leaf) and op
//   in_valid/in_ready      upstream handshake
//   out_result/out_op      reduced bit and the op that produced it
//   out_valid/out_ready    downstream handshake
module reduce_tree_pipe #(
  parameter int N_INPUTS         = 4,
  parameter int LEVELS_PER_STAGE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] in_data,
  input  logic [1:0]          in_op,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_result,
  output logic [1:0]          out_op,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int LEVELS = $clog2(N_INPUTS);
  localparam int DEPTH  = (LEVELS + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
  localparam int PAD_W  = 1 << LEVELS;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // Base 2-input gate for one tree node; NAND nodes are plain AND nodes.
  function automatic logic node_gate(input logic a, input logic b,
                                     input logic [1:0] op);
    logic r;
    case (op)
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Unused leaves take the identity element of the base op so they never
  // influence the result.
  function automatic logic [PAD_W-1:0] pad_leaves(input logic [N_INPUTS-1:0] d,
                                                  input logic [1:0] op);
    logic [PAD_W-1:0] v;
    v = {PAD_W{(op == OP_AND) || (op == OP_NAND)}};
    v[N_INPUTS-1:0] = d;
    return v;
  endfunction

  // Apply nlev tree levels. Each level pairs (2k, 2k+1) into k; the live part
  // of the vector halves per level and everything above it is zeroed.
  function automatic logic [PAD_W-1:0] fold_levels(input logic [PAD_W-1:0] v,
                                                   input logic [1:0] op,
                                                   input int nlev);
    logic [PAD_W-1:0] cur;
    logic [PAD_W-1:0] nxt;
    cur = v;
    for (int l = 0; l < LEVELS; l++) begin
      if (l < nlev) begin
        nxt = '0;
        for (int k = 0; k < PAD_W / 2; k++) begin
          nxt[k] = node_gate(cur[2*k], cur[2*k+1], op);
        end
        cur = nxt;
      end
    end
    return cur;
  endfunction

  logic [DEPTH-1:0]            ld;
  logic [DEPTH-1:0]            vld_d;
  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0][PAD_W-1:0] data_d;
  logic [DEPTH-1:0][PAD_W-1:0] data_q;
  logic [DEPTH-1:0][1:0]       op_d;
  logic [DEPTH-1:0][1:0]       op_q;

  // Stage k may load when it is empty or its successor loads this cycle.
  // Walking from the output back gives the whole ready chain in one pass.
  always_comb begin : ready_chain
    logic rdy;
    rdy = out_ready;
    ld  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy   = !vld_q[k] || rdy;
      ld[k] = rdy;
    end
  end

  assign in_ready = ld[0];

  always_comb begin : stage_next
    logic [DEPTH-1:0]            up_vld;
    logic [DEPTH-1:0][PAD_W-1:0] up_data;
    logic [DEPTH-1:0][1:0]       up_op;
    logic [PAD_W-1:0]            nxt;
    int                          nlev;

    vld_d  = vld_q;
    data_d = data_q;
    op_d   = op_q;
    nxt    = '0;
    nlev   = 0;

    up_vld[0]  = in_valid;
    up_data[0] = pad_leaves(in_data, in_op);
    up_op[0]   = in_op;
    for (int k = 1; k < DEPTH; k++) begin
      up_vld[k]  = vld_q[k-1];
      up_data[k] = data_q[k-1];
      up_op[k]   = op_q[k-1];
    end

    for (int k = 0; k < DEPTH; k++) begin
      // The last stage may own fewer levels than LEVELS_PER_STAGE.
      nlev = LEVELS - k * LEVELS_PER_STAGE;
      if (nlev > LEVELS_PER_STAGE) begin
        nlev = LEVELS_PER_STAGE;
      end
      if (ld[k]) begin
        nxt = fold_levels(up_data[k], up_op[k], nlev);
        // NAND inverts only the root, once the whole tree has been folded.
        if ((k == DEPTH - 1) && (up_op[k] == OP_NAND)) begin
          nxt[0] = !nxt[0];
        end
        // Loading from an empty upstream stage clears valid (a bubble).
        vld_d[k]  = up_vld[k];
        data_d[k] = nxt;
        op_d[k]   = up_op[k];
      end
    end
  end

  // Pipeline registers, stages 0..DEPTH-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
      op_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      op_q   <= op_d;
    end
  end

  assign out_valid  = vld_q[DEPTH-1];
  assign out_result = data_q[DEPTH-1][0];
  assign out_op     = op_q[DEPTH-1];

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Bench for reduce_tree_pipe: three instances (N=4/L=1, N=5/L=1, N=8/L=2)
// driven with directed vectors, an exhaustive N=5 stream, backpressure,
// bubble and mid-flight reset sequences.
module tb_reduce_tree_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [3:0] d4;
  logic [1:0] op4, oop4;
  logic       iv4, ir4, res4, ov4, or4;
  logic [4:0] d5;
  logic [1:0] op5, oop5;
  logic       iv5, ir5, res5, ov5, or5;
  logic [7:0] d8;
  logic [1:0] op8, oop8;
  logic       iv8, ir8, res8, ov8, or8;

  reduce_tree_pipe #(.N_INPUTS(4), .LEVELS_PER_STAGE(1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .in_op(op4), .in_valid(iv4),
    .in_ready(ir4), .out_result(res4), .out_op(oop4), .out_valid(ov4),
    .out_ready(or4));

  reduce_tree_pipe #(.N_INPUTS(5), .LEVELS_PER_STAGE(1)) u5 (
    .clk(clk), .rst_n(rst_n), .in_data(d5), .in_op(op5), .in_valid(iv5),
    .in_ready(ir5), .out_result(res5), .out_op(oop5), .out_valid(ov5),
    .out_ready(or5));

  reduce_tree_pipe #(.N_INPUTS(8), .LEVELS_PER_STAGE(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_data(d8), .in_op(op8), .in_valid(iv8),
    .in_ready(ir8), .out_result(res8), .out_op(oop8), .out_valid(ov8),
    .out_ready(or8));

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [1:0] op;
    logic       exp;
  } vec_t;

  vec_t tbl[17];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int id, input logic v, input logic [7:0] d, input logic [1:0] op);
    case (id)
      0: begin iv4 = v; d4 = d[3:0]; op4 = op; end
      1: begin iv5 = v; d5 = d[4:0]; op5 = op; end
      default: begin iv8 = v; d8 = d; op8 = op; end
    endcase
  endtask

  task automatic sample(input int id, output logic ov, output logic res,
                        output logic [1:0] op, output logic ir);
    case (id)
      0: begin ov = ov4; res = res4; op = oop4; ir = ir4; end
      1: begin ov = ov5; res = res5; op = oop5; ir = ir5; end
      default: begin ov = ov8; res = res8; op = oop8; ir = ir8; end
    endcase
  endtask

  function automatic int depth_of(input int id);
    return (id == 1) ? 3 : 2;
  endfunction

  function automatic logic ref5(input logic [4:0] d, input logic [1:0] op);
    case (op)
      2'b00:   return &d;
      2'b01:   return |d;
      2'b10:   return ^d;
      default: return ~&d;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: accept, measure edges to result, check value,
  // then make sure it is not presented twice.
  task automatic run_one(input int idx);
    logic ov, res, ir;
    logic [1:0] op;
    int edges;
    drive(tbl[idx].id, 1'b1, tbl[idx].data, tbl[idx].op);
    #1;
    sample(tbl[idx].id, ov, res, op, ir);
    chk($sformatf("tbl%0d_in_ready", idx), 32'(ir), 32'd1);
    tick();
    drive(tbl[idx].id, 1'b0, 8'h00, 2'b00);
    edges = 1;
    sample(tbl[idx].id, ov, res, op, ir);
    while (!ov && edges < 10) begin
      tick();
      edges++;
      sample(tbl[idx].id, ov, res, op, ir);
    end
    chk($sformatf("tbl%0d_latency", idx), 32'(edges), 32'(depth_of(tbl[idx].id)));
    chk($sformatf("tbl%0d_result", idx), 32'(res), 32'(tbl[idx].exp));
    chk($sformatf("tbl%0d_op", idx), 32'(op), 32'(tbl[idx].op));
    tick();
    sample(tbl[idx].id, ov, res, op, ir);
    chk($sformatf("tbl%0d_no_dup", idx), 32'(ov), 32'd0);
  endtask

  initial begin
    logic ov, res, ir;
    logic [1:0] op;
    logic [4:0] dj;
    logic [1:0] opj;
    int j;
    logic [4:0] bub_exp;

    tbl[0]  = '{0, 8'h0F, 2'b00, 1'b1};
    tbl[1]  = '{0, 8'h0D, 2'b00, 1'b0};
    tbl[2]  = '{0, 8'h00, 2'b01, 1'b0};
    tbl[3]  = '{0, 8'h04, 2'b01, 1'b1};
    tbl[4]  = '{0, 8'h07, 2'b10, 1'b1};
    tbl[5]  = '{0, 8'h06, 2'b10, 1'b0};
    tbl[6]  = '{0, 8'h0F, 2'b11, 1'b0};
    tbl[7]  = '{0, 8'h07, 2'b11, 1'b1};
    tbl[8]  = '{2, 8'hB1, 2'b10, 1'b0};
    tbl[9]  = '{2, 8'h00, 2'b01, 1'b0};
    tbl[10] = '{2, 8'hFF, 2'b11, 1'b0};
    tbl[11] = '{2, 8'hFE, 2'b11, 1'b1};
    tbl[12] = '{2, 8'hFF, 2'b00, 1'b1};
    tbl[13] = '{2, 8'h01, 2'b10, 1'b1};
    tbl[14] = '{1, 8'h1F, 2'b00, 1'b1};
    tbl[15] = '{1, 8'h10, 2'b01, 1'b1};
    tbl[16] = '{1, 8'h10, 2'b10, 1'b1};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00, 2'b00);
    or4 = 1'b1; or5 = 1'b1; or8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state on all instances
    for (int i = 0; i < 3; i++) begin
      sample(i, ov, res, op, ir);
      chk($sformatf("rst%0d_out_valid", i), 32'(ov), 32'd0);
      chk($sformatf("rst%0d_out_result", i), 32'(res), 32'd0);
      chk($sformatf("rst%0d_out_op", i), 32'(op), 32'd0);
      chk($sformatf("rst%0d_in_ready", i), 32'(ir), 32'd1);
    end
    rst_n = 1'b1;
    tick();
    sample(0, ov, res, op, ir);
    chk("post_rst_out_valid", 32'(ov), 32'd0);

    // Directed vectors
    for (int i = 0; i < 17; i++) run_one(i);

    // N=5 exhaustive stream, all ops back to back, DEPTH 3
    for (int c = 0; c < 130; c++) begin
      if (c < 128) drive(1, 1'b1, 8'(c % 32), 2'(c / 32));
      else drive(1, 1'b0, 8'h00, 2'b00);
      tick();
      sample(1, ov, res, op, ir);
      if (c >= 2) begin
        j   = c - 2;
        dj  = 5'(j % 32);
        opj = 2'(j / 32);
        chk($sformatf("sweep%0d_valid", j), 32'(ov), 32'd1);
        chk($sformatf("sweep%0d_result", j), 32'(res), 32'(ref5(dj, opj)));
        chk($sformatf("sweep%0d_op", j), 32'(op), 32'(opj));
      end else begin
        chk($sformatf("sweep_fill%0d_valid", c), 32'(ov), 32'd0);
      end
      if (c < 128) chk($sformatf("sweep%0d_in_ready", c), 32'(ir), 32'd1);
    end
    tick();
    sample(1, ov, res, op, ir);
    chk("sweep_drained_valid", 32'(ov), 32'd0);

    // Backpressure on N=4: A=AND 1101->0, B=XOR 0001->1, C=NAND 1111->0
    or4 = 1'b0;
    drive(0, 1'b1, 8'h0D, 2'b00);
    #1;
    sample(0, ov, res, op, ir);
    chk("bp_accept_a", 32'(ir), 32'd1);
    tick();
    drive(0, 1'b1, 8'h01, 2'b10);
    #1;
    sample(0, ov, res, op, ir);
    chk("bp_accept_b", 32'(ir), 32'd1);
    tick();
    drive(0, 1'b1, 8'h0F, 2'b11);
    #1;
    sample(0, ov, res, op, ir);
    chk("bp_full_in_ready", 32'(ir), 32'd0);
    for (int h = 0; h < 3; h++) begin
      tick();
      sample(0, ov, res, op, ir);
      chk($sformatf("bp_hold%0d_in_ready", h), 32'(ir), 32'd0);
      chk($sformatf("bp_hold%0d_valid", h), 32'(ov), 32'd1);
      chk($sformatf("bp_hold%0d_result", h), 32'(res), 32'd0);
      chk($sformatf("bp_hold%0d_op", h), 32'(op), 32'd0);
    end
    or4 = 1'b1;
    #1;
    sample(0, ov, res, op, ir);
    chk("bp_release_in_ready", 32'(ir), 32'd1);
    chk("bp_release_op_a", 32'(op), 32'd0);
    tick();
    drive(0, 1'b0, 8'h00, 2'b00);
    sample(0, ov, res, op, ir);
    chk("bp_b_valid", 32'(ov), 32'd1);
    chk("bp_b_result", 32'(res), 32'd1);
    chk("bp_b_op", 32'(op), 32'd2);
    tick();
    sample(0, ov, res, op, ir);
    chk("bp_c_valid", 32'(ov), 32'd1);
    chk("bp_c_result", 32'(res), 32'd0);
    chk("bp_c_op", 32'(op), 32'd3);
    tick();
    sample(0, ov, res, op, ir);
    chk("bp_empty_valid", 32'(ov), 32'd0);

    // Bubbles on N=4: in_valid 1,0,1 -> out_valid 1,0,1 one edge later
    bub_exp = 5'b01010;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive(0, 1'b1, 8'h01, 2'b01);
      else if (c == 2) drive(0, 1'b1, 8'h03, 2'b10);
      else drive(0, 1'b0, 8'h00, 2'b00);
      tick();
      sample(0, ov, res, op, ir);
      chk($sformatf("bub%0d_valid", c), 32'(ov), 32'(bub_exp[c]));
      if (c == 1) begin
        chk("bub1_result", 32'(res), 32'd1);
        chk("bub1_op", 32'(op), 32'd1);
      end
      if (c == 3) begin
        chk("bub3_result", 32'(res), 32'd0);
        chk("bub3_op", 32'(op), 32'd2);
      end
    end

    // Reset mid-flight on N=4 with two OR 1000 -> 1 transactions held
    or4 = 1'b0;
    drive(0, 1'b1, 8'h08, 2'b01);
    tick();
    tick();
    drive(0, 1'b0, 8'h00, 2'b00);
    sample(0, ov, res, op, ir);
    chk("mid_pre_valid", 32'(ov), 32'd1);
    chk("mid_pre_result", 32'(res), 32'd1);
    chk("mid_pre_in_ready", 32'(ir), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    sample(0, ov, res, op, ir);
    chk("mid_rst_valid", 32'(ov), 32'd0);
    chk("mid_rst_result", 32'(res), 32'd0);
    chk("mid_rst_op", 32'(op), 32'd0);
    chk("mid_rst_in_ready", 32'(ir), 32'd1);
    #1;
    rst_n = 1'b1;
    or4 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      sample(0, ov, res, op, ir);
      chk($sformatf("mid_after%0d_valid", c), 32'(ov), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a sequence ever stalls
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reduce_tree_pipe.md
# reduce_tree_pipe

Parametrised, pipelined N-input reduction tree that folds an N-bit input vector to a single bit with a per-transaction AND/OR/XOR/NAND operation. It is the general replacement for hand-instantiated trees of 2-input gates. Register stages are inserted every `LEVELS_PER_STAGE` tree levels. Ready/valid handshakes on both sides allow it to sit between any producer and consumer in the datapath.

## Interface
- `N_INPUTS`, default 4: number of input bits; legal range 2..64.
- `LEVELS_PER_STAGE`, default 1: combinational gate levels between pipeline registers; legal range ≥1.
- Derived `LEVELS` = ceil(log2(N_INPUTS)).
- Derived `DEPTH` = ceil(LEVELS / LEVELS_PER_STAGE): number of register stages and the latency in cycles.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  N_INPUTS  operand vector; bit 0 is the leftmost tree leaf.
- `in_op`  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
- `in_valid`  in  1  producer offers `in_data`/`in_op`.
- `in_ready`  out  1  block accepts this cycle.
- `out_result`  out  1  reduced bit.
- `out_op`  out  2  operation that produced `out_result`.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts.

## Operation
- Leaves are padded to 2^LEVELS with the identity element: 1 for AND/NAND, 0 for OR/XOR.
- Padding depends on `in_op` and is applied before the first gate level.
- Each tree node is a 2-input gate of the base op: AND for AND/NAND, OR, or XOR.
- Nodes pair adjacent indices (2k, 2k+1) at every level.
- NAND inverts the final root only; it is not a per-node NAND.
- Stage k (0..DEPTH-1) registers a `valid_k` flag, its partial-result vector, and the 2-bit op.
- The op travels with its data, so mixed-op streams are legal back to back.
- The last stage drives `out_result`, `out_op` and `out_valid` = `valid_{DEPTH-1}`.
- Stage k loads when `!valid_k || ready_{k+1}`, where `ready_DEPTH` = `out_ready`.
- `in_ready` = `!valid_0 || ready_1` (combinational chain; no registered skid).
- A stage that loads while its upstream is not valid clears its valid bit, which creates a bubble.
- A stalled stage holds its data and op unchanged.
- Transfers: input when `in_valid && in_ready`; output when `out_valid && out_ready`.
- Results are never dropped or duplicated, and order is strictly preserved.
- The block carries no width arithmetic; partial vectors halve in width per level.

## Timing
- On reset assertion, asynchronously: all `valid_k` = 0, partial vectors = 0, ops = 00.
- After reset: `out_valid` = 0, `out_result` = 0, `out_op` = 00, `in_ready` = 1.
- Reset mid-operation discards every in-flight transaction; nothing is emitted after release.
- Latency: a transaction accepted at edge t is visible on `out_*` after edge t+DEPTH−1 when there is no stall. It is therefore first presentable in the cycle following edge t+DEPTH−1.
- Throughput: one transaction per cycle while `out_ready` = 1.
- Full pipe (all valid) with `out_ready` = 0: `in_ready` = 0, and all stages hold.
- When `out_ready` rises with the pipe full, input and output transfer in the same cycle.
- Empty stages downstream of a stall still advance, so bubbles collapse.
- Outputs are not affected by `in_*` combinationally. `in_ready` depends combinationally on `out_ready`.

## Test plan
- N=4, L=1 (DEPTH 2), `out_ready`=1:
  - AND 4'b1111 → 1 two edges after accept.
  - AND 4'b1101 → 0 on the next cycle.
- N=5, L=1 (DEPTH 3), sweep all 32 inputs × 4 ops back to back:
  - every result matches a reference fold (AND/OR/XOR with identity padding; NAND = !AND).
  - `out_op` echoes the op, in order, one result per cycle.
- N=8, L=2 (DEPTH 2): XOR 8'b1011_0001 → 0; OR 8'h00 → 0; NAND 8'hFF → 0; NAND 8'hFE → 1. Each appears 2 edges after accept.
- Backpressure, N=4, L=1: with `out_ready`=0, push 3 transactions.
  - Exactly 2 are accepted; `in_ready` then stays 0.
  - Raise `out_ready`: results drain in order, with the third accepted in the same cycle the first leaves.
- Bubbles: `in_valid` toggling 1,0,1 with `out_ready` = 1 → `out_valid` pattern 1,0,1 delayed by DEPTH; no spurious results.
- Reset mid-flight: with 2 transactions in the pipe, pulse `rst_n` low for a partial cycle.
  - Asynchronously: `out_valid`=0, `out_result`=0, `in_ready`=1.
  - No stale results appear afterwards.
